// File: rtl/serial_add_sub.sv
// Bit-serial SIZE-bit adder/subtractor. It computes LSB-first, one bit per clock, and is
// bit-exact with the combinational unit: {Cout,S} = A + (B ^ {SIZE{sub}}) + sub.
module serial_add_sub #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            sub,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] S,
  output logic            Cout
);
  localparam int CW = $clog2(SIZE) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [SIZE-1:0] a_sh, b_sh, r_sh;
  logic            cy;
  logic [CW-1:0]   cnt;

  logic            sum_b, cy_nxt, last;
  logic [SIZE-1:0] r_nxt;

  assign sum_b  = a_sh[0] ^ b_sh[0] ^ cy;
  assign cy_nxt = (a_sh[0] & b_sh[0]) | (cy & (a_sh[0] ^ b_sh[0]));
  assign r_nxt  = {sum_b, r_sh[SIZE-1:1]};
  assign last   = (cnt == CW'(SIZE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction is two's-complement: invert B and inject sub as the carry-in.
            a_sh  <= A;
            b_sh  <= B ^ {SIZE{sub}};
            cy    <= sub;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_nxt;
          cy   <= cy_nxt;
          cnt  <= cnt + CW'(1);
          if (last) begin
            // The final sum bit is folded in directly, so S is complete on this edge.
            S     <= r_nxt;
            Cout  <= cy_nxt;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed SIZE=4 timing checks, then random SIZE=4 and SIZE=8
// operations compared against a plain-arithmetic reference.
module tb_serial_add_sub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start4 = 1'b0, sub4 = 1'b0, busy4, done4, cout4;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic       start8 = 1'b0, sub8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, s8;

  int n_cmp = 0;
  int n_err = 0;

  serial_add_sub #(.SIZE(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .sub(sub4),
    .busy(busy4), .done(done4), .S(s4), .Cout(cout4)
  );
  serial_add_sub #(.SIZE(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .sub(sub8),
    .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: {Cout,S} from plain integer arithmetic on an n-bit unit.
  function automatic logic [8:0] ref_op(input int n, input logic [7:0] a, input logic [7:0] b,
                                        input logic s);
    int r;
    logic c;
    if (s) begin
      r = int'(a) - int'(b);
      c = (a >= b);
    end else begin
      r = int'(a) + int'(b);
      c = (r >= (1 << n));
    end
    r = r & ((1 << n) - 1);
    return {c, r[7:0]};
  endfunction

  // Issue one SIZE=4 op (from IDLE or DONE) and check busy/done timing and result.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s);
    logic [8:0] e;
    e = ref_op(4, {4'b0, a}, {4'b0, b}, s);
    start4 = 1'b1; a4 = a; b4 = b; sub4 = s;
    tick();
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sub4 = 1'($urandom);
    for (int i = 1; i <= 4; i++) begin
      chk("busy4_run", busy4, 1);
      chk("done4_run", done4, 0);
      tick();
    end
    chk("done4", done4, 1);
    chk("busy4_done", busy4, 0);
    chk("s4", s4, e[3:0]);
    chk("cout4", cout4, e[8]);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [8:0] e;
    e = ref_op(8, a, b, s);
    start8 = 1'b1; a8 = a; b8 = b; sub8 = s;
    tick();
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    for (int i = 1; i <= 8; i++) begin
      chk("busy8_run", busy8, 1);
      chk("done8_run", done8, 0);
      tick();
    end
    chk("done8", done8, 1);
    chk("s8", s8, e[7:0]);
    chk("cout8", cout8, e[8]);
  endtask

  initial begin
    logic [8:0] e;
    int gap;

    // Reset state
    #12;
    chk("rst_s4", s4, 0);
    chk("rst_cout4", cout4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_s8", s8, 0);
    rst_n = 1'b1;
    tick();

    // Directed arithmetic with latency checks
    run4(4'd5, 4'd3, 1'b0);
    chk("add_5_3", {cout4, s4}, 5'd8);
    run4(4'd5, 4'd3, 1'b1);
    chk("sub_5_3", {cout4, s4}, {1'b1, 4'd2});
    run4(4'd3, 4'd5, 1'b1);
    chk("sub_3_5", {cout4, s4}, {1'b0, 4'd14});
    run4(4'd15, 4'd1, 1'b0);
    chk("add_15_1", {cout4, s4}, {1'b1, 4'd0});
    tick();
    chk("idle_done4", done4, 0);
    chk("idle_hold_s4", s4, 0);

    // start while busy is ignored
    start4 = 1'b1; a4 = 4'd5; b4 = 4'd3; sub4 = 1'b0;
    tick();
    start4 = 1'b0;
    tick();
    start4 = 1'b1; a4 = 4'd1; b4 = 4'd1; sub4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("ign_busy_c3", busy4, 1);
    tick();
    tick();
    chk("ign_done_c5", done4, 1);
    chk("ign_res", {cout4, s4}, 5'd8);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ign_no_2nd_done", done4, 0);
      chk("ign_no_busy", busy4, 0);
    end

    // start held high: done every 5 cycles
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd2; sub4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int c = 1; c <= 5; c++) begin
        tick();
        if (c == 5) begin
          chk("hold_done", done4, 1);
          chk("hold_busy_low", busy4, 0);
          chk("hold_res", {cout4, s4}, {1'b1, 4'd5});
        end else begin
          chk("hold_busy", busy4, 1);
          chk("hold_nodone", done4, 0);
        end
      end
    end
    start4 = 1'b0;
    tick();

    // Mid-operation reset abort
    run4(4'd9, 4'd4, 1'b0);
    chk("pre_rst_s", s4, 13);
    start4 = 1'b1; a4 = 4'd6; b4 = 4'd1; sub4 = 1'b0;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_s", s4, 0);
    chk("abort_cout", cout4, 0);
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_done", done4, 0);
    end
    rst_n = 1'b1;
    tick();
    run4(4'd6, 4'd1, 1'b0);
    chk("post_rst", {cout4, s4}, 5'd7);

    // Random operations with idle gaps
    for (int n = 0; n < 200; n++) begin
      run4(4'($urandom), 4'($urandom), 1'($urandom));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap4_done", done4, 0);
      end
    end
    for (int n = 0; n < 200; n++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap8_done", done8, 0);
      end
    end
    e = ref_op(8, 8'd200, 8'd100, 1'b0);
    run8(8'd200, 8'd100, 1'b0);
    chk("add8_ovf", {cout8, s8}, {e[8], e[7:0]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
